// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes the 16 bytes of a 128-bit state, SBOX_LANES
// bytes per clock, behind valid/ready handshakes on both sides.
module sub_bytes_iter #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] data_sbox,
    output logic         busy
);

    localparam int NUM_STEPS = 16 / SBOX_LANES;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    generate
        if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
            SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
            $error("sub_bytes_iter: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Forward S-box, row-major: entry b lives at bits [8b : 8b+7].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_step;
    logic [CNT_W-1:0] w_step_next;
    logic [0:127]     r_data;
    logic [0:127]     w_data_next;
    logic [6:0]       w_base;
    logic [6:0]       w_lane_idx [SBOX_LANES];
    logic [7:0]       w_lane_out [SBOX_LANES];

    assign w_base = 7'(int'(r_step) * SBOX_LANES * 8);

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        assign w_lane_idx[g] = w_base + 7'(8 * g);
        assign w_lane_out[g] = sbox(r_data[w_lane_idx[g] +: 8]);
    end

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_data_next  = r_data;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_data_next  = data_in;
                    w_step_next  = '0;
                    w_state_next = S_SUB;
                end
            end
            S_SUB: begin
                for (int l = 0; l < SBOX_LANES; l++) begin
                    w_data_next[w_lane_idx[l] +: 8] = w_lane_out[l];
                end
                if (r_step == LAST_STEP) begin
                    w_step_next  = '0;
                    w_state_next = S_DONE;
                end else begin
                    w_step_next = r_step + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the working register is reset too,
    // because data_sbox must read zero after reset and an aborted block must leave nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
            r_data  <= w_data_next;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign data_sbox = r_data;

endmodule
